mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage_load_align.sv | 38 +++
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage: datapath width, access
// sizes, FSM states and small alignment helpers.
package mem_stage_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    MEM_BYTE  = 2'd0,
    MEM_HALF  = 2'd1,
    MEM_WORD  = 2'd2,
    MEM_DWORD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  function automatic logic is_aligned(input logic [2:0] off, input mem_size_e size);
    logic ok;
    case (size)
      MEM_BYTE: ok = 1'b1;
      MEM_HALF: ok = (off[0] == 1'b0);
      MEM_WORD: ok = (off[1:0] == 2'b00);
      default:  ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] size_mask(input mem_size_e size);
    logic [7:0] m;
    case (size)
      MEM_BYTE: m = 8'h01;
      MEM_HALF: m = 8'h03;
      MEM_WORD: m = 8'h0F;
      default:  m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port of the memory stage.
interface mem_stage_if #(
  parameter int XLEN   = mem_stage_pkg::XLEN,
  parameter int STRB_W = XLEN / 8
);

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [XLEN-1:0]   dmem_req_addr;
  logic              dmem_req_write;
  logic [XLEN-1:0]   dmem_req_wdata;
  logic [STRB_W-1:0] dmem_req_wstrb;
  logic              dmem_resp_valid;
  logic [XLEN-1:0]   dmem_resp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_addr, dmem_req_write, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_addr, dmem_req_write, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load extraction: picks the addressed lane out of a dword read and
// zero/sign-extends it to the datapath width.
module load_align #(
  parameter int XLEN = mem_stage_pkg::XLEN
) (
  input  logic [XLEN-1:0]          rdata,
  input  logic [2:0]               offset,
  input  mem_stage_pkg::mem_size_e size,
  input  logic                     is_unsigned,
  output logic [XLEN-1:0]          data
);
  import mem_stage_pkg::*;

  logic [XLEN-1:0] shifted;
  logic            sign;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    sign    = 1'b0;
    data    = shifted;
    case (size)
      MEM_BYTE: begin
        sign = ~is_unsigned & shifted[7];
        data = {{(XLEN-8){sign}}, shifted[7:0]};
      end
      MEM_HALF: begin
        sign = ~is_unsigned & shifted[15];
        data = {{(XLEN-16){sign}}, shifted[15:0]};
      end
      MEM_WORD: begin
        sign = ~is_unsigned & shifted[31];
        data = {{(XLEN-32){sign}}, shifted[31:0]};
      end
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU ops straight through and sequences loads/stores
// over the data-memory port, stalling upstream until the access completes.
//   state | meaning
//   IDLE  | accept a new op; non-memory and misaligned ops complete here
//   REQ   | request presented, held until dmem_req_ready
//   WAIT  | waiting for dmem_resp_valid (load data or store ack)
//   DONE  | one-cycle writeback of the captured memory op
module mem_stage #(
  parameter int XLEN   = mem_stage_pkg::XLEN,
  parameter int STRB_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [1:0]      ex_mem_size,
  input  logic            ex_mem_unsigned,
  input  logic            ex_reg_write,
  input  logic            ex_mem_to_reg,
  input  logic [4:0]      ex_rd,
  mem_stage_if.master     dmem,
  output logic            mem_stall,
  output logic            misaligned_err,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic [XLEN-1:0] wb_load_data,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [4:0]      wb_rd
);
  import mem_stage_pkg::*;

  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  mem_size_e       size_q, size_d;
  logic            uns_q, uns_d;
  logic            write_q, write_d;
  logic            reg_write_q, reg_write_d;
  logic            m2r_q, m2r_d;
  logic [4:0]      rd_q, rd_d;

  logic            mem_op;
  logic            aligned;
  logic [XLEN-1:0] load_data;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (rdata_q),
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    rdata_d     = rdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    write_d     = write_q;
    reg_write_d = reg_write_q;
    m2r_d       = m2r_q;
    rd_d        = rd_q;

    mem_stall      = 1'b0;
    misaligned_err = 1'b0;
    wb_valid       = 1'b0;
    wb_reg_write   = 1'b0;
    wb_mem_to_reg  = 1'b0;
    wb_load_data   = '0;
    wb_alu_result  = '0;
    wb_rd          = '0;

    dmem.dmem_req_valid = 1'b0;
    dmem.dmem_req_addr  = '0;
    dmem.dmem_req_write = 1'b0;
    dmem.dmem_req_wdata = '0;
    dmem.dmem_req_wstrb = '0;

    mem_op  = ex_mem_read | ex_mem_write;
    aligned = is_aligned(ex_alu_result[2:0], mem_size_e'(ex_mem_size));

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (!mem_op) begin
            wb_valid      = 1'b1;
            wb_reg_write  = ex_reg_write && (ex_rd != 5'd0);
            wb_mem_to_reg = ex_mem_to_reg;
            wb_alu_result = ex_alu_result;
            wb_rd         = ex_rd;
          end else if (!aligned) begin
            // Retire the faulting op without a register write so the pipe keeps moving.
            misaligned_err = 1'b1;
            wb_valid       = 1'b1;
            wb_mem_to_reg  = ex_mem_to_reg;
            wb_alu_result  = ex_alu_result;
            wb_rd          = ex_rd;
          end else begin
            mem_stall   = 1'b1;
            state_d     = ST_REQ;
            addr_d      = ex_alu_result;
            sdata_d     = ex_store_data;
            rdata_d     = '0;
            size_d      = mem_size_e'(ex_mem_size);
            uns_d       = ex_mem_unsigned;
            write_d     = ex_mem_write;
            reg_write_d = ex_reg_write;
            m2r_d       = ex_mem_to_reg;
            rd_d        = ex_rd;
          end
        end
      end
      ST_REQ: begin
        mem_stall           = 1'b1;
        dmem.dmem_req_valid = 1'b1;
        dmem.dmem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
        dmem.dmem_req_write = write_q;
        dmem.dmem_req_wdata = sdata_q << {addr_q[2:0], 3'b000};
        dmem.dmem_req_wstrb = STRB_W'(size_mask(size_q)) << addr_q[2:0];
        if (dmem.dmem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        if (dmem.dmem_resp_valid) begin
          if (!write_q) rdata_d = dmem.dmem_resp_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        wb_valid      = 1'b1;
        wb_reg_write  = reg_write_q && (rd_q != 5'd0);
        wb_mem_to_reg = m2r_q;
        wb_load_data  = write_q ? '0 : load_data;
        wb_alu_result = addr_q;
        wb_rd         = rd_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      sdata_q     <= '0;
      rdata_q     <= '0;
      size_q      <= MEM_BYTE;
      uns_q       <= 1'b0;
      write_q     <= 1'b0;
      reg_write_q <= 1'b0;
      m2r_q       <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      rdata_q     <= rdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      write_q     <= write_d;
      reg_write_q <= reg_write_d;
      m2r_q       <= m2r_d;
      rd_q        <= rd_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [63:0] ex_alu_result = '0;
  logic [63:0] ex_store_data = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [1:0]  ex_mem_size = '0;
  logic        ex_mem_unsigned = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        mem_stall, misaligned_err, wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [63:0] wb_load_data, wb_alu_result;
  logic [4:0]  wb_rd;

  int n_chk  = 0;
  int n_pass = 0;

  mem_stage_if #(.XLEN(64)) dmem_if ();

  mem_stage #(.XLEN(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_alu_result   (ex_alu_result),
    .ex_store_data   (ex_store_data),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_size     (ex_mem_size),
    .ex_mem_unsigned (ex_mem_unsigned),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_rd           (ex_rd),
    .dmem            (dmem_if),
    .mem_stall       (mem_stall),
    .misaligned_err  (misaligned_err),
    .wb_valid        (wb_valid),
    .wb_reg_write    (wb_reg_write),
    .wb_mem_to_reg   (wb_mem_to_reg),
    .wb_load_data    (wb_load_data),
    .wb_alu_result   (wb_alu_result),
    .wb_rd           (wb_rd)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: the addressed bytes of the dword, then extended.
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                             input int nb, input logic uns);
    logic [63:0] v, mask;
    v    = rdata >> (8 * off);
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input int off, input int nb);
    logic [15:0] s;
    s = ((16'd1 << nb) - 16'd1) << off;
    return s[7:0];
  endfunction

  // Caller is #1 after a rising edge; returns at the same phase.
  task automatic run_op(input logic rd_op, input logic wr_op, input logic [1:0] size,
                        input logic uns, input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] rdata, input logic reg_wr, input logic m2r,
                        input logic [4:0] rd, input int rdy_dly, input int rsp_dly);
    int nb, off, req_end, resp_k, done_k;
    logic is_mem, ok;
    nb      = 1 << size;
    off     = int'(addr[2:0]);
    is_mem  = rd_op | wr_op;
    ok      = (off % nb) == 0;
    req_end = 1 + rdy_dly;
    resp_k  = req_end + 1 + rsp_dly;
    done_k  = resp_k + 1;

    ex_valid = 1'b1; ex_alu_result = addr; ex_store_data = sdata;
    ex_mem_read = rd_op; ex_mem_write = wr_op; ex_mem_size = size;
    ex_mem_unsigned = uns; ex_reg_write = reg_wr; ex_mem_to_reg = m2r; ex_rd = rd;
    dmem_if.dmem_req_ready = 1'b0;
    dmem_if.dmem_resp_valid = 1'b0;

    if (!is_mem || !ok) begin
      @(negedge clk);
      check_val("pass_stall", mem_stall, 0);
      check_val("pass_req_valid", dmem_if.dmem_req_valid, 0);
      check_val("misaligned_err", misaligned_err, is_mem);
      check_val("pass_wb_valid", wb_valid, 1);
      check_val("pass_wb_reg_write", wb_reg_write, !is_mem && reg_wr && (rd != 5'd0));
      check_val("pass_wb_rd", wb_rd, rd);
      check_val("pass_wb_alu", wb_alu_result, addr);
      check_val("pass_wb_m2r", wb_mem_to_reg, m2r);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      check_val("idle_misaligned", misaligned_err, 0);
      check_val("idle_req_valid", dmem_if.dmem_req_valid, 0);
      check_val("idle_stall", mem_stall, 0);
      check_val("idle_wb_valid", wb_valid, 0);
      @(posedge clk); #1;
    end else begin
      for (int k = 0; k <= done_k; k++) begin
        dmem_if.dmem_req_ready  = (k == req_end);
        dmem_if.dmem_resp_valid = (k == resp_k) ||
                                  ((k >= 1 && k <= req_end || k == done_k) && $urandom_range(0, 1) == 1);
        dmem_if.dmem_resp_rdata = (k == resp_k) ? rdata : {$urandom, $urandom};
        @(negedge clk);
        check_val("mem_stall", mem_stall, k < done_k);
        check_val("req_valid", dmem_if.dmem_req_valid, k >= 1 && k <= req_end);
        check_val("wb_valid", wb_valid, k == done_k);
        check_val("mem_misaligned", misaligned_err, 0);
        if (k >= 1 && k <= req_end) begin
          check_val("req_addr", dmem_if.dmem_req_addr, addr & ~64'h7);
          check_val("req_write", dmem_if.dmem_req_write, wr_op);
          if (wr_op) begin
            check_val("req_wdata", dmem_if.dmem_req_wdata, sdata << (8 * off));
            check_val("req_wstrb", dmem_if.dmem_req_wstrb, model_strb(off, nb));
          end
        end
        if (k == done_k) begin
          check_val("done_reg_write", wb_reg_write, reg_wr && (rd != 5'd0));
          check_val("done_m2r", wb_mem_to_reg, m2r);
          check_val("done_rd", wb_rd, rd);
          check_val("done_alu", wb_alu_result, addr);
          if (!wr_op) check_val("load_data", wb_load_data, model_load(rdata, off, nb, uns));
        end
        @(posedge clk); #1;
      end
      dmem_if.dmem_req_ready  = 1'b0;
      dmem_if.dmem_resp_valid = 1'b0;
    end
  endtask

  initial begin
    logic [1:0]  kind;
    logic [63:0] a;
    dmem_if.dmem_req_ready  = 1'b0;
    dmem_if.dmem_resp_valid = 1'b0;
    dmem_if.dmem_resp_rdata = '0;

    repeat (3) @(negedge clk);
    check_val("rst_req_valid", dmem_if.dmem_req_valid, 0);
    check_val("rst_stall", mem_stall, 0);
    check_val("rst_misaligned", misaligned_err, 0);
    check_val("rst_wb_valid", wb_valid, 0);
    check_val("rst_wb_reg_write", wb_reg_write, 0);
    check_val("rst_wb_m2r", wb_mem_to_reg, 0);
    check_val("rst_req_addr", dmem_if.dmem_req_addr, 0);
    check_val("rst_wb_load", wb_load_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 2'd0, 0, 64'h1234, 0, 0, 1, 1, 5'd5, 0, 0);
    run_op(1, 0, 2'd0, 0, 64'h1003, 0, 64'h0000_0000_8000_0000, 1, 0, 5'd7, 0, 0);
    run_op(0, 1, 2'd1, 0, 64'h2006, 64'hBEEF, 0, 0, 0, 5'd0, 4, 0);
    run_op(1, 0, 2'd2, 0, 64'h1002, 0, 0, 1, 0, 5'd9, 0, 0);
    run_op(1, 0, 2'd3, 1, 64'h3000, 0, 64'hDEAD_BEEF_0123_4567, 1, 0, 5'd0, 1, 2);

    // Reset while waiting for the response, then a stray response.
    ex_valid = 1'b1; ex_alu_result = 64'h4008; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_mem_size = 2'd3; ex_reg_write = 1'b1; ex_rd = 5'd3; ex_mem_to_reg = 1'b0;
    @(posedge clk); #1;
    dmem_if.dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_if.dmem_req_ready = 1'b0;
    reset = 1'b0;
    ex_valid = 1'b0;
    @(negedge clk);
    check_val("rstw_req_valid", dmem_if.dmem_req_valid, 0);
    check_val("rstw_stall", mem_stall, 0);
    check_val("rstw_wb_valid", wb_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    dmem_if.dmem_resp_valid = 1'b1;
    dmem_if.dmem_resp_rdata = 64'h5555_AAAA_5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("stray_wb_valid", wb_valid, 0);
      check_val("stray_stall", mem_stall, 0);
      check_val("stray_req_valid", dmem_if.dmem_req_valid, 0);
      @(posedge clk); #1;
      dmem_if.dmem_resp_valid = 1'b0;
    end

    for (int n = 0; n < 300; n++) begin
      kind = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) a[2:0] = 3'b000;
      run_op(kind == 2'd1 || kind == 2'd3, kind == 2'd2, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
